// File: rtl/data8_pkg.sv
// Shared types and width helpers for the data8_in byte deserializer.
package data8_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } d8_state_e;

  // Counter width for values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data8_gap_timer.sv
// Inter-byte gap counter: strobes timeout_o on the idle cycle that brings the gap to GAP_TIMEOUT.
module data8_gap_timer
  import data8_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic timeout_o
);

  localparam int unsigned GW = cnt_width(GAP_TIMEOUT);

  logic [GW-1:0] gap_q, gap_d;

  assign timeout_o = run_i && !clear_i && (gap_q == GW'(GAP_TIMEOUT - 1));

  always_comb begin
    gap_d = gap_q;
    if (clear_i || !run_i || timeout_o) gap_d = '0;
    else                                gap_d = gap_q + GW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gap_q <= '0;
    else         gap_q <= gap_d;
  end

endmodule

// File: rtl/data8_in.sv
// Byte-stream deserializer, first byte = MSB, with valid/ack hold handshake on the word.
// Optional inter-byte gap timeout enabled by defining D8IN_TIMEOUT_EN.
module data8_in
  import data8_pkg::*;
#(
  parameter int unsigned NOF_BYTES   = 3,
  parameter int unsigned GAP_TIMEOUT = 15
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic [8*NOF_BYTES-1:0] word_out,
  output logic                   word_valid,
  input  logic                   word_ack,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int unsigned W  = 8 * NOF_BYTES;
  localparam int unsigned AW = 8 * (NOF_BYTES - 1);
  localparam int unsigned CW = cnt_width(NOF_BYTES);

  d8_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   asm_q, asm_d;
  logic [W-1:0]    word_q, word_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout;

`ifdef D8IN_TIMEOUT_EN
  data8_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk_i    (pclk),
    .rst_ni   (rst_n),
    .clear_i  (din_valid),
    .run_i    (state_q == COLLECT),
    .timeout_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    word_d      = word_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    if (word_ack && valid_q) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          asm_d   = AW'(din);
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (cnt_q == CW'(NOF_BYTES - 1)) begin
            // Completion overrides a same-cycle ack; overrun only if the old word was never taken.
            word_d    = {asm_q, din};
            valid_d   = 1'b1;
            overrun_d = valid_q && !word_ack;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            asm_d = AW'({asm_q, din});
            cnt_d = cnt_q + CW'(1);
          end
        end else if (timeout) begin
          cnt_d       = '0;
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_data8_in.sv
// Directed bench for data8_in (NOF_BYTES=3, GAP_TIMEOUT=15); honours D8IN_TIMEOUT_EN.
module tb_data8_in;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic [23:0] word_out;
  logic        word_valid;
  logic        word_ack;
  logic        overrun;
  logic        frame_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data8_in #(
    .NOF_BYTES  (3),
    .GAP_TIMEOUT(15)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ack  (word_ack),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte for one clock; optionally ack in the same cycle.
  task automatic send(input logic [7:0] b, input logic ack);
    din       = b;
    din_valid = 1'b1;
    word_ack  = ack;
    @(negedge pclk);
    din_valid = 1'b0;
    word_ack  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    din_valid = 1'b0;
    word_ack  = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  task automatic ack_cycle();
    word_ack = 1'b1;
    @(negedge pclk);
    word_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; word_ack = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_word",  32'(word_out),  32'h0);
    check("rst_valid", 32'(word_valid), 32'h0);
    check("rst_ovr",   32'(overrun),   32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    rst_n = 1'b1;
    @(negedge pclk);

    // 1: basic word, hold until ack, ack while idle ignored
    send(8'hA1, 1'b0); send(8'hB2, 1'b0);
    check("t1_partial_valid", 32'(word_valid), 32'h0);
    send(8'hC3, 1'b0);
    check("t1_word",  32'(word_out),   32'hA1B2C3);
    check("t1_valid", 32'(word_valid), 32'h1);
    idle(3);
    check("t1_hold", 32'(word_valid), 32'h1);
    ack_cycle();
    check("t1_acked", 32'(word_valid), 32'h0);
    ack_cycle();
    check("t1_ack_idle", 32'(word_valid), 32'h0);
    check("t1_word_kept", 32'(word_out), 32'hA1B2C3);

    // 2: back-to-back with acks
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    check("t2_w0", 32'(word_out), 32'h010203);
    check("t2_v0", 32'(word_valid), 32'h1);
    send(8'h04, 1'b1);
    check("t2_v_cleared", 32'(word_valid), 32'h0);
    send(8'h05, 1'b0); send(8'h06, 1'b0);
    check("t2_w1", 32'(word_out), 32'h040506);
    check("t2_v1", 32'(word_valid), 32'h1);
    check("t2_ovr", 32'(overrun), 32'h0);
    ack_cycle();

    // 3: overrun on unacknowledged word
    send(8'h11, 1'b0); send(8'h11, 1'b0); send(8'h11, 1'b0);
    check("t3_w0", 32'(word_out), 32'h111111);
    check("t3_ovr0", 32'(overrun), 32'h0);
    send(8'h22, 1'b0); send(8'h22, 1'b0); send(8'h22, 1'b0);
    check("t3_ovr1", 32'(overrun), 32'h1);
    check("t3_w1", 32'(word_out), 32'h222222);
    check("t3_v1", 32'(word_valid), 32'h1);
    idle(1);
    check("t3_ovr_pulse", 32'(overrun), 32'h0);

    // 4: ack coinciding with completion
    send(8'h33, 1'b0); send(8'h34, 1'b0); send(8'h35, 1'b1);
    check("t4_word", 32'(word_out), 32'h333435);
    check("t4_valid", 32'(word_valid), 32'h1);
    check("t4_ovr", 32'(overrun), 32'h0);
    ack_cycle();
    check("t4_acked", 32'(word_valid), 32'h0);

    // 5: inter-byte gap
    send(8'h55, 1'b0); send(8'h66, 1'b0);
`ifdef D8IN_TIMEOUT_EN
    idle(14);
    check("t5_ferr_early", 32'(frame_err), 32'h0);
    idle(1);
    check("t5_ferr", 32'(frame_err), 32'h1);
    idle(1);
    check("t5_ferr_pulse", 32'(frame_err), 32'h0);
    check("t5_no_word", 32'(word_valid), 32'h0);
    send(8'h77, 1'b0); send(8'h88, 1'b0); send(8'h99, 1'b0);
    check("t5_word", 32'(word_out), 32'h778899);
    check("t5_valid", 32'(word_valid), 32'h1);
`else
    idle(100);
    check("t5_no_word", 32'(word_valid), 32'h0);
    check("t5_ferr", 32'(frame_err), 32'h0);
    send(8'h77, 1'b0);
    check("t5_word", 32'(word_out), 32'h556677);
    check("t5_valid", 32'(word_valid), 32'h1);
`endif

    // 6: async reset mid-word (word_valid still high from test 5)
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_word",  32'(word_out),   32'h0);
    check("t6_rst_valid", 32'(word_valid), 32'h0);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    send(8'hAB, 1'b0); send(8'hCD, 1'b0);
    check("t6_partial", 32'(word_valid), 32'h0);
    send(8'hEF, 1'b0);
    check("t6_word", 32'(word_out), 32'hABCDEF);
    check("t6_valid", 32'(word_valid), 32'h1);
    check("t6_ovr", 32'(overrun), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
